// File: rtl/aibnd_dcc_dll_calseq_pkg.sv
// Shared types, constants and parameter defaults for the DCC/DLL calibration sequencer.
// Includes a Gray-to-binary helper for capturing the PVT reference code.
package aibnd_dcc_dll_calseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_DCC_WAIT,
        ST_LOCK_WAIT,
        ST_CAPTURE,
        ST_DONE,
        ST_ERR
    } cal_state_e;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE      = 2'b00;
    localparam err_code_t ERR_DCC_TO    = 2'b01;
    localparam err_code_t ERR_LOCK_TO   = 2'b10;
    localparam err_code_t ERR_LOCK_LOST = 2'b11;

    localparam int RST_CYC_DEF   = 16;
    localparam int DCC_TO_DEF    = 4096;
    localparam int LOCK_TO_DEF   = 8192;
    localparam int MAX_RETRY_DEF = 3;

    localparam int CNT_W      = 13;
    localparam int PVT_W      = 10;
    localparam int CAP_TO     = 256;
    localparam int STABLE_CYC = 4;

    function automatic logic [PVT_W-1:0] gray2bin(input logic [PVT_W-1:0] g);
        logic [PVT_W-1:0] b;
        b[PVT_W-1] = g[PVT_W-1];
        for (int i = PVT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/aibnd_sync2.sv
// Two-flop bit synchronizer with synchronous active-high clear.
module aibnd_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // NOTE: sequential state uses non-blocking assignments so s2_q takes the old s1_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/aibnd_dcc_dll_calseq.sv
// Calibration sequencer: resets the DCC/DLL, waits for duty-cycle and lock, captures the
// PVT Gray code, and retries on timeout or (optionally) on lock loss.
module aibnd_dcc_dll_calseq
    import aibnd_dcc_dll_calseq_pkg::*;
#(
    parameter int RST_CYC   = RST_CYC_DEF,
    parameter int DCC_TO    = DCC_TO_DEF,
    parameter int LOCK_TO   = LOCK_TO_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic             clk_pll,
    input  logic             rst,
    input  logic             cal_start,
    input  logic             dcc_done,
    input  logic             odll_lock,
    input  logic [PVT_W-1:0] pvt_ref_half_gry,
    input  logic             rb_cont_cal,
    output logic             dcc_dll_nrst,
    output logic             dcc_dll_reinit,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_err,
    output logic [1:0]       err_code,
    output logic [1:0]       retry_cnt,
    output logic [PVT_W-1:0] pvt_code_bin
);

    localparam logic [CNT_W-1:0] RST_END   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] DCC_END   = CNT_W'(DCC_TO - 1);
    localparam logic [CNT_W-1:0] LOCK_END  = CNT_W'(LOCK_TO - 1);
    localparam logic [CNT_W-1:0] CAP_END   = CNT_W'(CAP_TO - 1);
    localparam logic [1:0]       STAB_END  = 2'(STABLE_CYC - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    cal_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    err_code_t        err_q, err_d;
    logic [1:0]       stab_q, stab_d;
    logic [PVT_W-1:0] gry_prev_q;
    logic [PVT_W-1:0] pvt_q, pvt_d;

    logic             dcc_done_s;
    logic             odll_lock_s;
    logic [PVT_W-1:0] gry_s;
    logic             gry_match;
    logic             to_fire;
    err_code_t        to_code;

    aibnd_sync2 u_sync_dcc  (.clk_i(clk_pll), .rst_i(rst), .d_i(dcc_done),  .q_o(dcc_done_s));
    aibnd_sync2 u_sync_lock (.clk_i(clk_pll), .rst_i(rst), .d_i(odll_lock), .q_o(odll_lock_s));

    for (genvar i = 0; i < PVT_W; i++) begin : g_pvt_sync
        aibnd_sync2 u_sync_pvt (.clk_i(clk_pll), .rst_i(rst), .d_i(pvt_ref_half_gry[i]), .q_o(gry_s[i]));
    end

    assign gry_match = (gry_s == gry_prev_q);

    // NOTE: reset is synchronous, so it is sampled inside the clocked block, not in the sensitivity list.
    always_ff @(posedge clk_pll) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            retry_q    <= '0;
            err_q      <= ERR_NONE;
            stab_q     <= '0;
            gry_prev_q <= '0;
            pvt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
            stab_q     <= stab_d;
            gry_prev_q <= gry_s;
            pvt_q      <= pvt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        err_d   = err_q;
        pvt_d   = pvt_q;
        to_fire = 1'b0;
        to_code = ERR_NONE;

        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (cal_start) begin
                    state_d = ST_RST_HOLD;
                    retry_d = '0;
                    err_d   = ERR_NONE;
                end
            end
            ST_RST_HOLD: if (cnt_q == RST_END) state_d = ST_DCC_WAIT;
            ST_DCC_WAIT: begin
                if (dcc_done_s)            state_d = ST_LOCK_WAIT;
                else if (cnt_q == DCC_END) begin to_fire = 1'b1; to_code = ERR_DCC_TO; end
            end
            ST_LOCK_WAIT: begin
                if (odll_lock_s)            state_d = ST_CAPTURE;
                else if (cnt_q == LOCK_END) begin to_fire = 1'b1; to_code = ERR_LOCK_TO; end
            end
            ST_CAPTURE: begin
                // Either a stable code or the capture window expiring takes the latest sample.
                if ((gry_match && stab_q == STAB_END) || cnt_q == CAP_END) begin
                    state_d = ST_DONE;
                    pvt_d   = gray2bin(gry_s);
                end
            end
            ST_DONE: begin
                if (cal_start) begin
                    state_d = ST_RST_HOLD;
                    retry_d = '0;
                    err_d   = ERR_NONE;
                end else if (!odll_lock_s) begin
                    if (rb_cont_cal) begin
                        to_fire = 1'b1;
                        to_code = ERR_LOCK_LOST;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_LOCK_LOST;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (to_fire) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 2'd1;
                state_d = ST_RST_HOLD;
            end else begin
                state_d = ST_ERR;
                err_d   = to_code;
            end
        end

        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q == '1)    cnt_d = cnt_q;
        else                     cnt_d = cnt_q + CNT_W'(1);

        stab_d = (state_q == ST_CAPTURE && gry_match) ? stab_q + 2'd1 : 2'd0;
    end

    always_comb begin
        dcc_dll_nrst   = 1'b1;
        dcc_dll_reinit = 1'b0;
        cal_busy       = 1'b0;
        cal_done       = 1'b0;
        cal_err        = 1'b0;
        unique case (state_q)
            ST_IDLE:      dcc_dll_nrst = 1'b0;
            ST_RST_HOLD:  begin dcc_dll_nrst = 1'b0; cal_busy = 1'b1; end
            ST_DCC_WAIT:  begin cal_busy = 1'b1; dcc_dll_reinit = (cnt_q == '0); end
            ST_LOCK_WAIT: cal_busy = 1'b1;
            ST_CAPTURE:   cal_busy = 1'b1;
            ST_DONE:      cal_done = 1'b1;
            ST_ERR:       begin dcc_dll_nrst = 1'b0; cal_err = 1'b1; end
            default:      dcc_dll_nrst = 1'b0;
        endcase
    end

    assign err_code     = err_q;
    assign retry_cnt    = retry_q;
    assign pvt_code_bin = pvt_q;

endmodule

// File: tb/tb_aibnd_dcc_dll_calseq.sv
// Directed bench for the calibration sequencer: nominal run, DCC timeout exhaustion,
// Gray capture, lock loss handling, reset abort and ignored mid-sequence start.
module tb_aibnd_dcc_dll_calseq;

    logic       clk_pll = 1'b0;
    logic       rst;
    logic       cal_start;
    logic       dcc_done;
    logic       odll_lock;
    logic [9:0] pvt_ref_half_gry;
    logic       rb_cont_cal;
    logic       dcc_dll_nrst;
    logic       dcc_dll_reinit;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_err;
    logic [1:0] err_code;
    logic [1:0] retry_cnt;
    logic [9:0] pvt_code_bin;

    int checks   = 0;
    int failures = 0;

    aibnd_dcc_dll_calseq dut (
        .clk_pll          (clk_pll),
        .rst              (rst),
        .cal_start        (cal_start),
        .dcc_done         (dcc_done),
        .odll_lock        (odll_lock),
        .pvt_ref_half_gry (pvt_ref_half_gry),
        .rb_cont_cal      (rb_cont_cal),
        .dcc_dll_nrst     (dcc_dll_nrst),
        .dcc_dll_reinit   (dcc_dll_reinit),
        .cal_busy         (cal_busy),
        .cal_done         (cal_done),
        .cal_err          (cal_err),
        .err_code         (err_code),
        .retry_cnt        (retry_cnt),
        .pvt_code_bin     (pvt_code_bin)
    );

    always #5 clk_pll = ~clk_pll;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_pll);
        #1;
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0:       return cal_done;
            1:       return cal_err;
            2:       return cal_busy && !dcc_dll_nrst;
            default: return dcc_dll_reinit;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag);
        logic hit = 1'b0;
        int   cyc = 0;
        while (!hit && cyc < budget) begin
            if (cond(sel)) hit = 1'b1;
            else begin tick(); cyc++; end
        end
        check(tag, 16'(hit), 16'd1);
    endtask

    initial begin
        int   hold_n, reinit_n, reinit_at, done_at, err_at;
        logic activity;

        rst = 1'b1; cal_start = 1'b0; dcc_done = 1'b0; odll_lock = 1'b0;
        rb_cont_cal = 1'b0; pvt_ref_half_gry = 10'b1100000000;
        repeat (3) tick();
        check("rst_nrst",   16'(dcc_dll_nrst), 16'd0);
        check("rst_busy",   16'(cal_busy),     16'd0);
        check("rst_done",   16'(cal_done),     16'd0);
        check("rst_err",    16'(cal_err),      16'd0);
        check("rst_reinit", 16'(dcc_dll_reinit), 16'd0);
        check("rst_code",   16'(err_code),     16'd0);
        check("rst_retry",  16'(retry_cnt),    16'd0);
        check("rst_pvt",    16'(pvt_code_bin), 16'd0);

        // Nominal run: dcc_done at cycle 40, lock at cycle 100 after the start edge.
        rst = 1'b0; tick();
        cal_start = 1'b1; tick(); cal_start = 1'b0;
        hold_n = 0; reinit_n = 0; reinit_at = -1; done_at = -1;
        for (int c = 0; c < 400 && done_at < 0; c++) begin
            if (cal_busy && !dcc_dll_nrst) hold_n++;
            if (dcc_dll_reinit) begin reinit_n++; reinit_at = c; end
            if (cal_done) done_at = c;
            if (c == 40)  dcc_done = 1'b1;
            if (c == 100) odll_lock = 1'b1;
            if (done_at < 0) tick();
        end
        check("nom_hold_cycles", 16'(hold_n),    16'd16);
        check("nom_reinit_cnt",  16'(reinit_n),  16'd1);
        check("nom_reinit_at",   16'(reinit_at), 16'd16);
        check("nom_done_at",     16'(done_at),   16'd107);
        check("nom_nrst",        16'(dcc_dll_nrst), 16'd1);
        check("nom_busy",        16'(cal_busy),  16'd0);
        check("nom_retry",       16'(retry_cnt), 16'd0);
        check("nom_code",        16'(err_code),  16'd0);
        check("nom_pvt",         16'(pvt_code_bin), 16'b1000000000);

        // Captured code must not follow the input while in DONE.
        pvt_ref_half_gry = 10'b0101010101;
        repeat (8) tick();
        check("pvt_hold", 16'(pvt_code_bin), 16'b1000000000);

        // Start and lock loss in the same DONE cycle: start wins even with rb_cont_cal=0.
        odll_lock = 1'b0; dcc_done = 1'b0;
        tick(); tick();
        cal_start = 1'b1; tick(); cal_start = 1'b0;
        check("race_busy",  16'(cal_busy),     16'd1);
        check("race_nrst",  16'(dcc_dll_nrst), 16'd0);
        check("race_err",   16'(cal_err),      16'd0);
        check("race_code",  16'(err_code),     16'd0);

        // dcc_done stuck low: four attempts of 16+4096 cycles, then ERR.
        reinit_n = 0; err_at = -1;
        for (int c = 0; c < 20000 && err_at < 0; c++) begin
            if (dcc_dll_reinit) reinit_n++;
            if (cal_err) err_at = c;
            if (err_at < 0) tick();
        end
        check("dccto_reinit_cnt", 16'(reinit_n), 16'd4);
        check("dccto_err_at",     16'(err_at),   16'd16448);
        check("dccto_code",       16'(err_code), 16'b01);
        check("dccto_retry",      16'(retry_cnt), 16'd3);
        check("dccto_nrst",       16'(dcc_dll_nrst), 16'd0);
        check("dccto_busy",       16'(cal_busy), 16'd0);

        // Restart from ERR clears status; start during DCC_WAIT is ignored.
        pvt_ref_half_gry = 10'b0000000111;
        cal_start = 1'b1; tick(); cal_start = 1'b0;
        check("restart_retry", 16'(retry_cnt), 16'd0);
        check("restart_code",  16'(err_code),  16'd0);
        check("restart_busy",  16'(cal_busy),  16'd1);
        wait_for(3, 100, "wait_reinit");
        cal_start = 1'b1; tick(); tick(); cal_start = 1'b0; tick();
        check("ign_start_nrst",   16'(dcc_dll_nrst),   16'd1);
        check("ign_start_busy",   16'(cal_busy),       16'd1);
        check("ign_start_reinit", 16'(dcc_dll_reinit), 16'd0);

        // Reset while in LOCK_WAIT aborts immediately.
        dcc_done = 1'b1;
        repeat (5) tick();
        rst = 1'b1; tick();
        check("abort_nrst",   16'(dcc_dll_nrst), 16'd0);
        check("abort_busy",   16'(cal_busy),     16'd0);
        check("abort_done",   16'(cal_done),     16'd0);
        check("abort_err",    16'(cal_err),      16'd0);
        check("abort_reinit", 16'(dcc_dll_reinit), 16'd0);
        check("abort_retry",  16'(retry_cnt),    16'd0);
        check("abort_pvt",    16'(pvt_code_bin), 16'd0);
        rst = 1'b0;
        activity = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (dcc_dll_reinit || cal_busy || dcc_dll_nrst) activity = 1'b1;
        end
        check("abort_quiet", 16'(activity), 16'd0);

        // Lock loss in DONE: auto-relock with rb_cont_cal=1, then ERR with rb_cont_cal=0.
        odll_lock = 1'b1;
        cal_start = 1'b1; tick(); cal_start = 1'b0;
        wait_for(0, 300, "wait_done1");
        check("gry_pvt",   16'(pvt_code_bin), 16'b0000000101);
        check("gry_retry", 16'(retry_cnt),    16'd0);

        rb_cont_cal = 1'b1; odll_lock = 1'b0;
        wait_for(2, 10, "wait_relock_hold");
        check("relock_retry", 16'(retry_cnt), 16'd1);
        check("relock_code",  16'(err_code),  16'd0);
        check("relock_done",  16'(cal_done),  16'd0);
        odll_lock = 1'b1;
        wait_for(0, 300, "wait_done2");
        check("relock2_retry", 16'(retry_cnt), 16'd1);

        rb_cont_cal = 1'b0; odll_lock = 1'b0;
        wait_for(1, 10, "wait_lost_err");
        check("lost_code", 16'(err_code),     16'b11);
        check("lost_nrst", 16'(dcc_dll_nrst), 16'd0);
        check("lost_done", 16'(cal_done),     16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
